// File: rtl/sisc_seq.sv
// sisc_seq: SISC instruction sequencer owning pc and ir, fetching over a req/ack handshake,
// handing non-branch instructions to the datapath and resolving branches against stat.
module sisc_seq #(
    parameter int             AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_f,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    input  logic [3:0]    stat,
    input  logic          exec_done,
    output logic [31:0]   ir,
    output logic [AW-1:0] pc,
    output logic          exec_start,
    output logic          halted
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, EXEC, UPDATE, HALT} state_t;

    state_t     state, state_nxt;
    logic       exec_first;
    logic [3:0] op, m;
    logic       is_branch, taken;

    assign op        = ir[31:28];
    assign m         = ir[27:24] & stat;
    assign is_branch = (op == 4'h2) || (op == 4'h4);
    // BRA takes on any selected flag set, BNE on none set (so BNE with mm=0 always jumps)
    assign taken     = ((op == 4'h2) && (m != 4'h0)) || ((op == 4'h4) && (m == 4'h0));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = imem_ack ? LOAD : FETCH;
            LOAD:    state_nxt = is_branch ? UPDATE : (op == 4'hF) ? HALT : EXEC;
            EXEC:    state_nxt = exec_done ? UPDATE : EXEC;
            UPDATE:  state_nxt = FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state      <= IDLE;
            exec_first <= 1'b0;
            ir         <= '0;
            pc         <= RESET_PC;
        end else begin
            state      <= state_nxt;
            exec_first <= (state == LOAD);
            if (state == FETCH && imem_ack)
                ir <= imem_rdata;
            if (state == UPDATE)
                pc <= taken ? ir[AW-1:0] : pc + AW'(1);
        end
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc;
    assign exec_start = (state == EXEC) && exec_first;
    assign halted     = (state == HALT);
endmodule

// File: tb/tb_sisc_seq.sv
// tb_sisc_seq: table-driven and randomized checks of sisc_seq against an instruction-level model.
module tb_sisc_seq;
    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [3:0]  stat = '0;
    logic        exec_done = 1'b0;
    logic [31:0] ir;
    logic [15:0] pc;
    logic        exec_start;
    logic        halted;

    int checks = 0;
    int errors = 0;
    logic [15:0] mpc = 16'h0;
    logic [31:0] mir = 32'h0;

    sisc_seq #(.AW(16), .RESET_PC(16'h0)) dut (
        .clk(clk), .rst_f(rst_f), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stat(stat), .exec_done(exec_done),
        .ir(ir), .pc(pc), .exec_start(exec_start), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  st;
        int          aw;
        int          dw;
        logic [15:0] exp_pc;
        int          exp_cyc;
        int          exp_starts;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_next(input logic [15:0] p, input logic [31:0] i,
                                               input logic [3:0] s);
        logic [3:0] mm;
        mm = i[27:24] & s;
        if (i[31:28] == 4'h2) return (mm != 4'h0) ? i[15:0] : p + 16'd1;
        if (i[31:28] == 4'h4) return (mm == 4'h0) ? i[15:0] : p + 16'd1;
        return p + 16'd1;
    endfunction

    // Runs one instruction starting in its first FETCH cycle; returns in the next FETCH or HALT
    task automatic run_instr(input logic [31:0] instr, input logic [3:0] st, input int aw,
                             input int dw, input logic [15:0] exp_pc, input int exp_cyc,
                             input int exp_starts);
        int n, starts, k;
        logic [15:0] pc0;
        pc0 = mpc;
        n = 0; starts = 0; k = -1;
        stat = st;
        exec_done = 1'b0;
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, mpc);
        for (int i = 0; i < aw; i++) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            exec_done = 1'($urandom_range(0, 1));
            tick();
            n++;
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, pc0);
            chk("wait_ir", ir, mir);
        end
        imem_ack = 1'b1;
        imem_rdata = instr;
        tick();
        n++;
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        chk("ir_load", ir, instr);
        mir = instr;
        while (!(imem_req === 1'b1 || halted === 1'b1) && n < 100) begin
            imem_ack = 1'($urandom_range(0, 1));
            if (exec_start === 1'b1) begin
                starts++;
                k = 0;
            end
            if (k >= 0) begin
                exec_done = (k == dw);
                k = (k == dw) ? -1 : k + 1;
            end else
                exec_done = 1'($urandom_range(0, 1));
            chk("pc_stable", pc, pc0);
            tick();
            n++;
            chk("ir_stable", ir, mir);
        end
        imem_ack = 1'b0;
        exec_done = 1'b0;
        chk("cycles", n, exp_cyc);
        chk("exec_starts", starts, exp_starts);
        if (instr[31:28] == 4'hF)
            chk("halted", halted, 1);
        else begin
            chk("next_addr", imem_addr, exp_pc);
            mpc = exp_pc;
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_req"}, imem_req, 0);
        chk({nm, "_start"}, exec_start, 0);
        chk({nm, "_halted"}, halted, 0);
        chk({nm, "_pc"}, pc, 0);
        chk({nm, "_ir"}, ir, 0);
    endtask

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{32'h1000_0000, 4'h0, 0, 0, 16'h0001, 4, 1};
        tbl[1]  = '{32'h3000_0000, 4'h0, 0, 0, 16'h0002, 4, 1};
        tbl[2]  = '{32'h5000_0000, 4'h0, 0, 0, 16'h0003, 4, 1};
        tbl[3]  = '{32'h2100_0040, 4'h1, 0, 0, 16'h0040, 3, 0};
        tbl[4]  = '{32'h2100_0040, 4'h0, 0, 0, 16'h0041, 3, 0};
        tbl[5]  = '{32'h4000_0010, 4'hF, 0, 0, 16'h0010, 3, 0};
        tbl[6]  = '{32'h4000_0003, 4'h0, 0, 0, 16'h0003, 3, 0};
        tbl[7]  = '{32'h6000_0000, 4'h0, 3, 0, 16'h0004, 7, 1};
        tbl[8]  = '{32'h7000_0000, 4'h0, 0, 5, 16'h0005, 9, 1};
        tbl[9]  = '{32'h8123_4567, 4'h0, 3, 2, 16'h0006, 9, 1};
        tbl[10] = '{32'h4800_1234, 4'h8, 0, 0, 16'h0007, 3, 0};
        tbl[11] = '{32'h2600_0ABC, 4'h4, 0, 0, 16'h0ABC, 3, 0};
        tbl[12] = '{32'h4000_FFFF, 4'h0, 1, 0, 16'hFFFF, 4, 0};
        tbl[13] = '{32'h9000_0000, 4'h0, 0, 0, 16'h0000, 4, 1};
        tbl[14] = '{32'h4A00_0020, 4'h5, 0, 0, 16'h0020, 3, 0};

        #1;
        chk_reset_vals("rst_async");
        tick();
        tick();
        rst_f = 1'b1;
        chk("idle_req", imem_req, 0);
        tick();
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 0);

        foreach (tbl[i])
            run_instr(tbl[i].instr, tbl[i].st, tbl[i].aw, tbl[i].dw,
                      tbl[i].exp_pc, tbl[i].exp_cyc, tbl[i].exp_starts);

        for (int i = 0; i < 150; i++) begin
            logic [3:0] op, st;
            logic [31:0] instr;
            int aw, dw, br;
            op = ($urandom_range(0, 5) < 2) ? 4'h2 : 4'h4;
            if ($urandom_range(0, 2) == 0) begin
                op = 4'($urandom_range(0, 14));
                if (op == 4'h2 || op == 4'h4) op = op + 4'h1;
            end
            instr = {op, 4'($urandom), 24'($urandom)};
            st = 4'($urandom);
            aw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            br = (op == 4'h2 || op == 4'h4) ? 1 : 0;
            run_instr(instr, st, aw, dw, model_next(mpc, instr, st),
                      br ? aw + 3 : aw + 4 + dw, br ? 0 : 1);
        end

        run_instr(32'hF000_0000, 4'h0, 1, 0, mpc, 3, 0);
        for (int i = 0; i < 10; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            tick();
            chk("halt_req", imem_req, 0);
            chk("halt_flag", halted, 1);
            chk("halt_pc", pc, mpc);
            chk("halt_ir", ir, 32'hF000_0000);
            chk("halt_start", exec_start, 0);
        end
        imem_ack = 1'b0;
        exec_done = 1'b0;

        rst_f = 1'b0;
        #1;
        chk_reset_vals("rst_halt");
        tick();
        rst_f = 1'b1;
        tick();
        mpc = 16'h0;
        mir = 32'h0;
        tick();
        chk("fetch_pending_req", imem_req, 1);
        rst_f = 1'b0;
        #1;
        chk_reset_vals("rst_fetch");
        tick();
        rst_f = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_ir", ir, 0);
        chk("late_ack_req", imem_req, 1);
        chk("late_ack_addr", imem_addr, 0);

        run_instr(32'h4000_0033, 4'h0, 0, 0, 16'h0033, 3, 0);
        imem_ack = 1'b1;
        imem_rdata = 32'h1000_0000;
        tick();
        imem_ack = 1'b0;
        tick();
        chk("exec_pre_rst_start", exec_start, 1);
        chk("exec_pre_rst_pc", pc, 16'h0033);
        rst_f = 1'b0;
        #1;
        chk_reset_vals("rst_exec");
        tick();
        rst_f = 1'b1;
        tick();
        tick();
        mpc = 16'h0;
        mir = 32'h0;
        run_instr(32'h1000_0000, 4'h0, 0, 0, 16'h0001, 4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sisc_seq.md
# sisc_seq

Instruction sequencer for the SISC processor. It owns the program counter and the instruction register, and fetches 32-bit instructions from instruction memory over a request/acknowledge handshake. For non-branch instructions it hands execution to the datapath control through an exec_start/exec_done handshake. It then resolves conditional branches against the status register output and advances the PC. It sits between instruction memory and the `ir` bus that feeds the control unit, the register file and the ALU.

## Interface
- AW, 16, PC and instruction-memory address width
- RESET_PC, 0, PC value loaded on reset (AW bits)

- clk  in  1  system clock, all state updates on rising edge
- rst_f  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  AW  fetch address; always equals pc
- imem_ack  in  1  fetch complete; imem_rdata valid in this cycle
- imem_rdata  in  32  fetched instruction
- stat  in  4  status register output; bit 3 C, bit 2 V, bit 1 N, bit 0 Z
- exec_done  in  1  datapath control has finished the current instruction
- ir  out  32  instruction register
- pc  out  AW  program counter
- exec_start  out  1  one-cycle pulse starting execution of `ir`
- halted  out  1  sequencer stopped on HALT

## Operation
- States: IDLE, FETCH, LOAD, EXEC, UPDATE, HALT.
- IDLE: entered on reset. Moves to FETCH on the next clock.
- FETCH:
  - imem_req=1, and imem_addr=pc is held stable until imem_ack.
  - On imem_ack, ir ← imem_rdata and the state moves to LOAD.
  - Without imem_ack, the state stays in FETCH.
- LOAD: decode ir[31:28].
  - 0x2, 0x4 (branches): go to UPDATE.
  - 0xF: go to HALT.
  - Any other opcode: go to EXEC.
- EXEC:
  - exec_start=1 in the first EXEC cycle only.
  - Stays in EXEC until exec_done=1 is sampled, then goes to UPDATE.
  - exec_done sampled in the first EXEC cycle gives a 1-cycle execute.
- UPDATE: compute the next pc, then go to FETCH.
  - m = ir[27:24] & stat.
  - Opcode 0x2 (BRA): if m≠0, pc ← ir[AW-1:0]; else pc ← pc+1.
  - Opcode 0x4 (BNE): if m==0, pc ← ir[AW-1:0]; else pc ← pc+1.
    - BNE with mm=0 is an unconditional jump.
    - BRA with mm=0 is never taken.
  - All other opcodes: pc ← pc+1.
- HALT: halted=1. pc and ir frozen. Only reset exits.
- Arithmetic and widths:
  - pc+1 wraps modulo 2^AW, so (2^AW−1)+1 gives 0.
  - When AW<16, the branch target is truncated to ir[AW-1:0].
- Inputs ignored outside the relevant state:
  - imem_ack is ignored outside FETCH.
  - exec_done is ignored outside EXEC.
  - stat is sampled only in UPDATE.
- Branch and HALT instructions never assert exec_start.

## Timing
- Reset values, applied asynchronously on rst_f=0:
  - state IDLE, pc=RESET_PC, ir=0.
  - imem_req=0, exec_start=0, halted=0.
- Reset mid-operation (any state) aborts immediately:
  - imem_req drops in the same cycle.
  - An ack for the aborted request arriving after reset release is ignored, because the sequencer is then in IDLE.
- First imem_req is asserted 1 cycle after rst_f deasserts (IDLE→FETCH).
- Minimum instruction period, with ack in the first FETCH cycle:
  - Non-branch: 4 cycles (FETCH, LOAD, EXEC, UPDATE) when exec_done arrives in the first EXEC cycle.
  - Branch: 3 cycles (FETCH, LOAD, UPDATE).
- ir changes only on the edge that ends an acknowledged FETCH cycle. It is stable throughout LOAD, EXEC and UPDATE.
- pc changes only on the edge leaving UPDATE.
- The PC value of a taken branch is visible on imem_addr in the next FETCH cycle.
- exec_start is high for exactly one cycle per executed instruction, even if EXEC lasts many cycles.
- Each wait is unbounded with no timeout: imem_ack in FETCH, exec_done in EXEC.

## Test plan
- Reset release, RESET_PC=0, memory acks immediately, exec_done tied 1 → imem_req rises 1 cycle after release; addresses 0,1,2 fetched; exec_start pulses every 4 cycles.
- imem_ack delayed 3 cycles at address 5 → imem_req and imem_addr=5 held for 4 cycles; ir unchanged until the ack edge.
- BRA with mm=0001, stat Z=1, target 0x0040 → next fetch address 0x40, no exec_start. Same instruction with stat=0000 → next fetch address pc+1.
- BNE with mm=0000 at pc=0x10, target 0x0003 → jumps to 0x3. pc=0xFFFF with a non-branch opcode, AW=16 → next fetch at 0x0000.
- exec_done withheld for 5 cycles → exactly one exec_start pulse and no fetch until exec_done. Opcode 0xF → halted=1, imem_req stays 0 permanently.
- rst_f pulsed low during EXEC and during FETCH with a pending request → all outputs return to reset values immediately; a late imem_ack does not load ir.
